timer_sequencer: RTL and testbench
==================================

# timer_sequencer

Avalon-MM slave peripheral that sequences a programmable countdown timer for the Nios II lab systems. The timer's reload value comes from the switches (push-button command) or from software. The timer is started, stopped and restarted either by push buttons or by register writes. Expiry is reported on a status output that drives the red LEDs, and on a level interrupt to the CPU. The block sits on the system interconnect beside the PIO and JTAG UART components.

## Interface
- PRESCALE, 50: clock cycles per timer tick (1 µs at 50 MHz); legal range ≥ 1.
- CNT_W, 32: width of the reload and count registers; legal range 17–32.

- CLOCK_50_I  in  1  system clock; all logic on its rising edge.
- RESET_I  in  1  synchronous, active-high reset.
- SWITCH_I  in  17  reload source for the button LOAD command; zero-extended to CNT_W.
- PUSH_BUTTON_I  in  4  [0] START, [1] LOAD; [3:2] unused; active-high, asynchronous.
- avs_address  in  2  register select.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt = expired_flag & irq_en.
- STATUS_O  out  4  [0] idle/ready, [1] config valid, [2] running, [3] expired flag.

## Operation
- Registers:
  - 0 RELOAD (RW): a write also sets config valid.
  - 1 CTRL (W bit0 LOAD-from-switches, bit1 START, bit2 STOP are self-clearing pulses; bit3 irq_en is RW).
  - 2 STATUS (R = {28'b0, STATUS_O}; W bit0=1 clears the expired flag).
  - 3 COUNT (R; current count, zero-extended).
- Reads and writes are ignored unless avs_chipselect is high.
- Push buttons pass through a 2-flop synchronizer followed by a rising-edge detector. One press produces one command pulse.
- States:
  - IDLE: no valid config.
  - ARMED: config valid, stopped.
  - RUN: counting.
  - EXPIRED: count reached 0.
- LOAD:
  - reload ← SWITCH_I, config valid ← 1.
  - IDLE→ARMED; other states unchanged.
  - LOAD in RUN updates reload only; the running count is untouched.
- START:
  - Ignored in IDLE.
  - Otherwise count ← reload, prescaler ← 0, state → RUN, expired flag ← 0. This applies from ARMED, from EXPIRED, and as a restart from RUN.
- STOP:
  - RUN→ARMED; count and prescaler are held.
  - No effect in other states.
- In RUN:
  - The prescaler counts 0..PRESCALE-1. On wrap a tick occurs and count decrements.
  - When count is 0 at a tick, or START was issued with reload = 0: state → EXPIRED, expired flag ← 1.
  - Count stays at 0 in EXPIRED.
- The expired flag is sticky. It clears only on a STATUS write with bit0=1, on START, or on reset. The EXPIRED state persists after the flag is cleared.
- Same-cycle conflicts:
  - Register commands beat button commands; the button pulse is dropped.
  - STOP beats START within one CTRL write.
  - LOAD and START in one write: LOAD is applied first, so START uses the new reload.
  - A tick and a STOP in the same cycle: the decrement is applied, then the block stops.

## Timing
- Reset, one cycle with RESET_I high, sets:
  - state IDLE; reload 0; count 0; prescaler 0.
  - config valid 0; irq_en 0; expired flag 0.
  - avs_readdata 0; irq 0; STATUS_O = 4'b0001.
- Reset mid-run aborts immediately; there is no pending interrupt afterwards.
- Register writes take effect at the clock edge where avs_write & avs_chipselect is sampled.
- Reads have a fixed latency of 1 cycle: avs_readdata is valid the cycle after the read strobe. No wait states.
- Button-to-command latency is 3 cycles from the input change: 2 synchronizer cycles plus 1 edge-detect cycle.
- START to first decrement takes PRESCALE cycles.
- START with reload N to EXPIRED takes (N+1)·PRESCALE cycles.
- STATUS_O and irq are registered; they update the cycle after the state change.

## Test plan
- Reset, then read STATUS → 0x1; START pressed while IDLE → state stays IDLE, STATUS_O = 0x1.
- PRESCALE=4. Set SWITCH_I = 0x00003 and pulse PUSH_BUTTON_I[1] → STATUS_O = 0x2, RELOAD reads 3. Then pulse PUSH_BUTTON_I[0] → STATUS_O = 0x6; EXPIRED (STATUS_O = 0xA) is reached exactly 16 cycles after the START command.
- Write RELOAD = 10 and CTRL = 0x8 (irq_en), then START via CTRL=0x2. Expect irq high after 44 cycles. Write STATUS=1 → irq low next cycle, STATUS_O = 0x2.
- While RUN, write CTRL = 0x4 at count = 5 → STATUS_O = 0x2 and COUNT stays 5 for 20 cycles. Write CTRL = 0x2 → COUNT reads the reload value again.
- In the same cycle, write CTRL = 0x6 and issue a button START → STOP wins. The state does not enter RUN, and the button pulse is dropped.
- Assert RESET_I for 1 cycle mid-RUN with irq_en set → next cycle all outputs take their reset values, irq = 0, RELOAD reads 0.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer: Avalon-MM countdown timer sequencer with push-button
// and register command paths, sticky expiry flag and level interrupt.
module timer_sequencer #(
  parameter int PRESCALE = 50,
  parameter int CNT_W    = 32
) (
  input  logic        CLOCK_50_I,
  input  logic        RESET_I,
  input  logic [16:0] SWITCH_I,
  input  logic [3:0]  PUSH_BUTTON_I,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic [3:0]  STATUS_O
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_EXPIRED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             cfg_q, cfg_d;
  logic             irq_en_q, irq_en_d;
  logic             flag_q, flag_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       status_q, status_d;
  logic             irq_q, irq_d;
  logic [1:0]       sync1_q, sync2_q, prev_q;

  logic wr_en, rd_en, ctrl_wr, drop_btn;
  logic btn_start, btn_load;
  logic do_load, do_start, do_stop, tick;
  logic unused_bits;

  assign unused_bits = ^{PUSH_BUTTON_I[3:2], avs_writedata[31:4]};

  assign wr_en     = avs_chipselect & avs_write;
  assign rd_en     = avs_chipselect & avs_read;
  assign ctrl_wr   = wr_en & (avs_address == 2'd1);
  assign drop_btn  = wr_en & ~avs_address[1];
  assign btn_start = sync2_q[0] & ~prev_q[0];
  assign btn_load  = sync2_q[1] & ~prev_q[1];
  assign do_stop   = ctrl_wr & avs_writedata[2];
  assign do_load   = (ctrl_wr & avs_writedata[0])
                   | (btn_load & ~drop_btn);
  assign do_start  = ((ctrl_wr & avs_writedata[1])
                   | (btn_start & ~drop_btn)) & ~do_stop;
  assign tick      = (presc_q == PMAX);

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    count_d  = count_q;
    presc_d  = presc_q;
    cfg_d    = cfg_q;
    irq_en_d = irq_en_q;
    flag_d   = flag_q;
    if (wr_en && avs_address == 2'd0) begin
      reload_d = avs_writedata[CNT_W-1:0];
      cfg_d    = 1'b1;
    end
    if (do_load) begin
      reload_d = CNT_W'(SWITCH_I);
      cfg_d    = 1'b1;
    end
    if (ctrl_wr) irq_en_d = avs_writedata[3];
    if (wr_en && avs_address == 2'd2 && avs_writedata[0])
      flag_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_d) state_d = S_ARMED;
      end
      S_RUN: begin
        if (tick) begin
          presc_d = '0;
          if (count_q == '0) begin
            state_d = S_EXPIRED;
            flag_d  = 1'b1;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // a tick in the same cycle still decrements before stopping
        if (do_stop && state_d == S_RUN) state_d = S_ARMED;
      end
      default: ;
    endcase
    if (do_start && cfg_d) begin
      count_d = reload_d;
      presc_d = '0;
      state_d = S_RUN;
      flag_d  = 1'b0;
    end
  end

  always_comb begin
    status_d = {flag_d, state_d == S_RUN,
                cfg_d, state_d == S_IDLE};
    irq_d    = flag_d & irq_en_d;
    rdata_d  = rdata_q;
    if (rd_en) begin
      unique case (avs_address)
        2'd0:    rdata_d = 32'(reload_q);
        2'd1:    rdata_d = {28'd0, irq_en_q, 3'd0};
        2'd2:    rdata_d = {28'd0, status_q};
        default: rdata_d = 32'(count_q);
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q  <= S_IDLE;
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      cfg_q    <= 1'b0;
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      rdata_q  <= '0;
      status_q <= 4'b0001;
      irq_q    <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      cfg_q    <= cfg_d;
      irq_en_q <= irq_en_d;
      flag_q   <= flag_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      sync1_q  <= PUSH_BUTTON_I[1:0];
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  assign avs_readdata = rdata_q;
  assign STATUS_O     = status_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: vector table, directed corner sequences and
// random traffic against an elapsed-time reference model.
module tb_timer_sequencer;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] sw;
  logic [3:0]  pb;
  logic [1:0]  addr;
  logic        cs, rd, wr;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic        irq;
  logic [3:0]  st;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  timer_sequencer #(.PRESCALE(P), .CNT_W(32)) dut (
    .CLOCK_50_I    (clk),
    .RESET_I       (rst),
    .SWITCH_I      (sw),
    .PUSH_BUTTON_I (pb),
    .avs_address   (addr),
    .avs_chipselect(cs),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wd),
    .avs_readdata  (rdata),
    .irq           (irq),
    .STATUS_O      (st)
  );

  // model: 0 idle, 1 armed, 2 run, 3 expired
  int          m_mode;
  bit          m_cfg, m_irqen, m_flag;
  longint      m_reload, m_start, m_elapsed;
  logic [31:0] m_rdata;
  logic [1:0]  h1, h2, h3;

  function automatic longint m_count();
    longint c;
    c = m_start - m_elapsed / P;
    return (c < 0) ? 0 : c;
  endfunction

  function automatic logic [3:0] m_status();
    return {m_flag, m_mode == 2, m_cfg, m_mode == 0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_step();
    logic ws, cw, drop, bs, bl, ld, go, stp;
    if (rst) begin
      m_mode = 0; m_cfg = 0; m_irqen = 0; m_flag = 0;
      m_reload = 0; m_start = 0; m_elapsed = 0;
      m_rdata = '0; h1 = '0; h2 = '0; h3 = '0;
      return;
    end
    if (cs && rd) begin
      case (addr)
        2'd0:    m_rdata = 32'(m_reload);
        2'd1:    m_rdata = {28'd0, m_irqen, 3'd0};
        2'd2:    m_rdata = {28'd0, m_status()};
        default: m_rdata = 32'(m_count());
      endcase
    end
    ws   = cs && wr;
    cw   = ws && addr == 2'd1;
    drop = ws && addr <= 2'd1;
    bs   = h2[0] && !h3[0] && !drop;
    bl   = h2[1] && !h3[1] && !drop;
    h3 = h2; h2 = h1; h1 = pb[1:0];
    stp = cw && wd[2];
    ld  = (cw && wd[0]) || bl;
    go  = ((cw && wd[1]) || bs) && !stp;
    if (ws && addr == 2'd0) begin m_reload = longint'(wd); m_cfg = 1; end
    if (ld) begin m_reload = longint'(sw); m_cfg = 1; end
    if (cw) m_irqen = wd[3];
    if (ws && addr == 2'd2 && wd[0]) m_flag = 0;
    if (m_mode == 2) begin
      m_elapsed++;
      if (m_elapsed == (m_start + 1) * P) begin
        m_mode = 3; m_flag = 1;
      end else if (stp) begin
        m_mode = 1;
      end
    end else if (m_mode == 0 && m_cfg) begin
      m_mode = 1;
    end
    if (go && m_cfg) begin
      m_mode = 2; m_start = m_reload; m_elapsed = 0; m_flag = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_status", 32'(st), 32'(m_status()));
    chk("model_irq", 32'(irq), 32'(m_flag && m_irqen));
    chk("model_rdata", rdata, m_rdata);
  endtask

  task automatic idle();
    cs = 0; wr = 0; rd = 0; addr = '0; wd = '0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; wd = d;
    cyc();
    idle();
  endtask

  task automatic rd_reg(input logic [1:0] a, input string nm,
                        input logic [31:0] exp);
    cs = 1; wr = 0; rd = 1; addr = a;
    cyc();
    idle();
    chk(nm, rdata, exp);
  endtask

  typedef struct {
    logic        cs, wr, rd;
    logic [1:0]  a;
    logic [31:0] d;
    logic [16:0] sw;
    logic [3:0]  st;
    logic        irq;
    logic [31:0] rdat;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic w, input logic r,
                              input logic [1:0] a, input logic [31:0] d,
                              input logic [16:0] s, input logic [3:0] e,
                              input logic i, input logic [31:0] rv);
    vec_t v;
    v.cs = c; v.wr = w; v.rd = r; v.a = a; v.d = d; v.sw = s;
    v.st = e; v.irq = i; v.rdat = rv;
    return v;
  endfunction

  vec_t tbl[17];
  int   n;

  initial begin
    tbl[0]  = mk(1, 1, 0, 1, 32'h2, 0, 4'h1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 32'h8, 0, 4'h1, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h0, 0, 4'h2, 0, 0);
    tbl[3]  = mk(1, 1, 0, 1, 32'hA, 0, 4'h6, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0, 0, 4'h6, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0, 0, 4'h6, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0, 0, 4'h6, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0, 0, 4'hA, 1, 0);
    tbl[8]  = mk(1, 1, 0, 2, 32'h1, 0, 4'h2, 0, 0);
    tbl[9]  = mk(1, 1, 0, 1, 32'h4, 0, 4'h2, 0, 0);
    tbl[10] = mk(1, 1, 0, 1, 32'h3, 2, 4'h6, 0, 0);
    tbl[11] = mk(1, 1, 0, 1, 32'h6, 0, 4'h2, 0, 0);
    tbl[12] = mk(1, 0, 1, 3, 32'h0, 0, 4'h2, 0, 2);
    tbl[13] = mk(1, 0, 1, 0, 32'h0, 0, 4'h2, 0, 2);
    tbl[14] = mk(1, 0, 1, 1, 32'h0, 0, 4'h2, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 32'h7, 0, 4'h2, 0, 0);
    tbl[16] = mk(1, 0, 1, 0, 32'h0, 0, 4'h2, 0, 2);

    rst = 1; sw = '0; pb = '0;
    idle();
    cyc();
    chk("reset_status", 32'(st), 32'h1);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      cs = tbl[i].cs; wr = tbl[i].wr; rd = tbl[i].rd;
      addr = tbl[i].a; wd = tbl[i].d; sw = tbl[i].sw;
      cyc();
      chk($sformatf("tbl%0d_status", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
      if (tbl[i].rd)
        chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdat);
      idle();
    end

    rst = 1; cyc(); rst = 0;
    rd_reg(2, "idle_status_read", 32'h1);
    pb = 4'h1;
    repeat (5) cyc();
    chk("start_in_idle", 32'(st), 32'h1);
    pb = 4'h0;
    repeat (2) cyc();

    sw = 17'h3; pb = 4'h2;
    cyc(); cyc();
    chk("btn_load_lat2", 32'(st), 32'h1);
    cyc();
    chk("btn_load_lat3", 32'(st), 32'h2);
    pb = 4'h0;
    rd_reg(0, "reload_from_sw", 32'h3);
    pb = 4'h1;
    cyc(); cyc(); cyc();
    chk("btn_start", 32'(st), 32'h6);
    pb = 4'h0;
    n = 0;
    while (st != 4'hA && n < 40) begin cyc(); n++; end
    chk("expire_cycles", 32'(n), 32'd16);

    wr_reg(2, 32'h1);
    wr_reg(0, 32'd10);
    wr_reg(1, 32'h8);
    wr_reg(1, 32'hA);
    chk("run_status", 32'(st), 32'h6);
    n = 0;
    while (!irq && n < 100) begin cyc(); n++; end
    chk("irq_cycles", 32'(n), 32'd44);
    wr_reg(2, 32'h1);
    chk("irq_cleared", 32'(irq), 32'h0);
    chk("cleared_status", 32'(st), 32'h2);

    wr_reg(1, 32'hA);
    repeat (20) cyc();
    wr_reg(1, 32'h4);
    chk("stop_status", 32'(st), 32'h2);
    repeat (20) cyc();
    rd_reg(3, "count_held", 32'd5);
    wr_reg(1, 32'h2);
    rd_reg(3, "count_restart", 32'd10);

    wr_reg(1, 32'h4);
    pb = 4'h1;
    cyc(); cyc();
    cs = 1; wr = 1; addr = 2'd1; wd = 32'h6;
    cyc();
    idle();
    chk("stop_beats_start", 32'(st), 32'h2);
    pb = 4'h0;
    repeat (4) cyc();
    chk("btn_dropped", 32'(st), 32'h2);

    wr_reg(1, 32'hA);
    repeat (6) cyc();
    rst = 1; cyc(); rst = 0;
    chk("midrun_reset_status", 32'(st), 32'h1);
    chk("midrun_reset_irq", 32'(irq), 32'h0);
    chk("midrun_reset_rdata", rdata, 32'h0);
    rd_reg(0, "reload_after_reset", 32'h0);
    repeat (10) cyc();
    chk("no_pending_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      int op;
      rst  = ($urandom_range(0, 299) == 0);
      cs   = ($urandom_range(0, 7) != 0);
      op   = $urandom_range(0, 11);
      wr   = (op < 2);
      rd   = (op == 2 || op == 3);
      addr = 2'($urandom_range(0, 3));
      wd   = (addr == 2'd0) ? $urandom_range(1, 12)
                            : $urandom_range(0, 15);
      sw   = 17'($urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) pb = 4'($urandom_range(0, 15));
      cyc();
    end
    rst = 0;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
